// File: rtl/piano_disp_pkg.sv
// Purpose : shared definitions for the piano display status path (FSM encoding, progress scale, divider length).
// Latency : n/a (package only).
// Backpressure: n/a.
package piano_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DIV     = 2'd2,
    ST_PEND    = 2'd3
  } disp_state_t;

  // Progress is expressed in percent.
  localparam int PROGRESS_MAX = 100;

  // idx*100 needs 7 extra bits over the index width (100 < 2^7).
  localparam int DIV_EXTRA_BITS = 7;

  // Dividend width, and therefore the number of cycles spent dividing.
  function automatic int div_len(input int idx_w);
    return idx_w + DIV_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Purpose : restoring unsigned divider, one quotient bit per cycle.
// Latency : DVD_W cycles from i_start to o_done; quotient valid the cycle after o_done.
// Backpressure: none; i_start restarts the division at any time.
//
// Ports:
//   clk_vga, iReset_n   clock, async active-low reset
//   i_start             load dividend/divisor and begin
//   i_dividend          DVD_W-bit dividend
//   i_divisor           DVS_W-bit divisor (0 yields all-ones; caller handles it)
//   o_done              high during the final step cycle
//   o_quotient          quotient; held stable once the division ends
module seq_divider #(
  parameter int DVD_W = 19,
  parameter int DVS_W = 12
) (
  input  logic             clk_vga,
  input  logic             iReset_n,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_dividend,
  input  logic [DVS_W-1:0] i_divisor,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(DVD_W + 1);

  logic [DVD_W-1:0] r_quo;   // dividend bits shift out the top, quotient bits shift in
  logic [DVS_W-1:0] r_rem;
  logic [DVS_W-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [DVS_W:0]   w_rem_sh;
  logic             w_ge;
  logic [DVS_W-1:0] w_diff;

  assign w_rem_sh = {r_rem, r_quo[DVD_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  // When w_ge holds the true difference is below the divisor, so the low bits suffice.
  assign w_diff   = w_rem_sh[DVS_W-1:0] - r_dvs;

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_start) begin
      r_quo <= i_dividend;
      r_rem <= '0;
      r_dvs <= i_divisor;
      r_cnt <= CNT_W'(DVD_W);
      r_run <= 1'b1;
    end else if (r_run) begin
      r_quo <= {r_quo[DVD_W-2:0], w_ge};
      r_rem <= w_ge ? w_diff : w_rem_sh[DVS_W-1:0];
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_run <= 1'b0;
    end
  end

  assign o_done     = r_run && (r_cnt == CNT_W'(1));
  assign o_quotient = r_quo;

endmodule

// File: rtl/display_status_latch.sv
// Purpose : take player status across clock domains, compute progress %, publish once per frame.
// Latency : SYNC_STAGES+2+IDX_W+7 cycles toggle->result, then held until the next iFrameStart.
// Backpressure: none; a newer bundle during DIV is queued (one deep), during PEND it replaces the result.
//
// Ports:
//   clk_vga, iReset_n          pixel clock, async active-low reset
//   iUpdTgl                    toggles once per new status bundle (foreign domain)
//   iFreqType/iNoteIdx/
//   iNoteTotal/iSongSelected   status bundle, stable while iUpdTgl is stable
//   iFrameStart                one-cycle pulse at start of vertical blanking
//   oFreqType/oProgress/
//   oSongSelected              frame-stable published status
//   oBusy                      high in CAPTURE or DIV
module display_status_latch
  import piano_disp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 12
) (
  input  logic             clk_vga,
  input  logic             iReset_n,
  input  logic             iUpdTgl,
  input  logic [7:0]       iFreqType,
  input  logic [IDX_W-1:0] iNoteIdx,
  input  logic [IDX_W-1:0] iNoteTotal,
  input  logic [3:0]       iSongSelected,
  input  logic             iFrameStart,
  output logic [7:0]       oFreqType,
  output logic [7:0]       oProgress,
  output logic [3:0]       oSongSelected,
  output logic             oBusy
);

  localparam int DIV_W = div_len(IDX_W);

  // Toggle synchroniser plus edge-detect flop; reset value 0 is the reference level.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_edge;
  logic                   w_req;

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      r_sync <= '0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iUpdTgl};
      r_edge <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_req = r_sync[SYNC_STAGES-1] ^ r_edge;

  disp_state_t r_state, w_nxt;
  logic        r_pend;
  logic        w_busy, w_start, w_commit;
  logic        w_div_done;

  // State register
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) r_state <= ST_IDLE;
    else           r_state <= w_nxt;
  end

  // Next state; a request in PEND beats a simultaneous frame start.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_req) w_nxt = ST_CAPTURE;
      ST_CAPTURE: w_nxt = ST_DIV;
      ST_DIV:     if (w_div_done) w_nxt = ST_PEND;
      ST_PEND: begin
        if (w_req)            w_nxt = ST_CAPTURE;
        else if (iFrameStart) w_nxt = r_pend ? ST_CAPTURE : ST_IDLE;
      end
      default:    w_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy   = (r_state == ST_CAPTURE) || (r_state == ST_DIV);
    w_start  = (r_state == ST_CAPTURE);
    w_commit = (r_state == ST_PEND) && iFrameStart && !w_req;
  end

  // Pending flag: a bundle that arrived while busy. Leaving PEND always
  // recaptures the latest inputs when set, so it is cleared there.
  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n)
      r_pend <= 1'b0;
    else if ((r_state == ST_PEND) && (w_req || iFrameStart))
      r_pend <= 1'b0;
    else if (w_req && w_busy)
      r_pend <= 1'b1;
  end

  // Captured fields; the divider registers the dividend/divisor on the same edge.
  logic [7:0]       r_freq;
  logic [3:0]       r_song;
  logic [IDX_W-1:0] r_total;
  logic [DIV_W-1:0] w_dividend;
  logic [DIV_W-1:0] w_quo;
  logic [7:0]       w_result;

  assign w_dividend = DIV_W'(iNoteIdx) * DIV_W'(PROGRESS_MAX);

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      r_freq  <= '0;
      r_song  <= '0;
      r_total <= '0;
    end else if (w_start) begin
      r_freq  <= iFreqType;
      r_song  <= iSongSelected;
      r_total <= iNoteTotal;
    end
  end

  seq_divider #(
    .DVD_W (DIV_W),
    .DVS_W (IDX_W)
  ) u_div (
    .clk_vga    (clk_vga),
    .iReset_n   (iReset_n),
    .i_start    (w_start),
    .i_dividend (w_dividend),
    .i_divisor  (iNoteTotal),
    .o_done     (w_div_done),
    .o_quotient (w_quo)
  );

  // Zero total reads as 0%; idx beyond total saturates at 100%.
  always_comb begin
    w_result = w_quo[7:0];
    if (r_total == '0)
      w_result = '0;
    else if (w_quo > DIV_W'(PROGRESS_MAX))
      w_result = 8'(PROGRESS_MAX);
  end

  always_ff @(posedge clk_vga or negedge iReset_n) begin
    if (!iReset_n) begin
      oFreqType     <= '0;
      oProgress     <= '0;
      oSongSelected <= '0;
    end else if (w_commit) begin
      oFreqType     <= r_freq;
      oProgress     <= w_result;
      oSongSelected <= r_song;
    end
  end

  assign oBusy = w_busy;

endmodule

// File: tb/tb_display_status_latch.sv
module tb_display_status_latch;

  logic        clk_vga = 1'b0;
  logic        iReset_n;
  logic        iUpdTgl;
  logic [7:0]  iFreqType;
  logic [11:0] iNoteIdx;
  logic [11:0] iNoteTotal;
  logic [3:0]  iSongSelected;
  logic        iFrameStart;
  logic [7:0]  oFreqType;
  logic [7:0]  oProgress;
  logic [3:0]  oSongSelected;
  logic        oBusy;

  int n_assert = 0;
  int n_fail   = 0;

  always #8 clk_vga = ~clk_vga;

  display_status_latch #(
    .SYNC_STAGES (2),
    .IDX_W       (12)
  ) dut (
    .clk_vga       (clk_vga),
    .iReset_n      (iReset_n),
    .iUpdTgl       (iUpdTgl),
    .iFreqType     (iFreqType),
    .iNoteIdx      (iNoteIdx),
    .iNoteTotal    (iNoteTotal),
    .iSongSelected (iSongSelected),
    .iFrameStart   (iFrameStart),
    .oFreqType     (oFreqType),
    .oProgress     (oProgress),
    .oSongSelected (oSongSelected),
    .oBusy         (oBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_vga);
  endtask

  task automatic check_out(input string tag, input int freq, input int prog, input int song);
    check({tag, ".freq"}, 32'(oFreqType), 32'(freq));
    check({tag, ".prog"}, 32'(oProgress), 32'(prog));
    check({tag, ".song"}, 32'(oSongSelected), 32'(song));
  endtask

  task automatic set_in(input int idx, input int total, input int freq, input int song);
    iNoteIdx      = 12'(idx);
    iNoteTotal    = 12'(total);
    iFreqType     = 8'(freq);
    iSongSelected = 4'(song);
  endtask

  // Flip the toggle, then record the first cycle oBusy is seen and how long it stays high.
  task automatic toggle_measure(output int first, output int cnt);
    first = -1;
    cnt   = 0;
    iUpdTgl = ~iUpdTgl;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_vga);
      if (oBusy) begin
        if (first < 0) first = i;
        cnt++;
      end else if (first >= 0) begin
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (oBusy && k < 100) begin
      @(negedge clk_vga);
      k++;
    end
    check({tag, ".idle_timeout"}, 32'(oBusy), 32'd0);
  endtask

  task automatic frame_pulse();
    iFrameStart = 1'b1;
    @(negedge clk_vga);
    iFrameStart = 1'b0;
  endtask

  initial begin
    int first, cnt, nb;
    iReset_n    = 1'b0;
    iUpdTgl     = 1'b0;
    iFrameStart = 1'b0;
    set_in(0, 0, 0, 0);

    // Reset state
    tick(3);
    check_out("reset", 0, 0, 0);
    check("reset.busy", 32'(oBusy), 32'd0);
    iReset_n = 1'b1;

    // No request without a toggle change
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_vga);
      if (oBusy) nb++;
    end
    check("post_reset.no_req", 32'(nb), 32'd0);

    // 50/200 -> 25
    set_in(50, 200, 20, 1);
    toggle_measure(first, cnt);
    check("s1.busy_first", 32'(first), 32'd3);
    check("s1.busy_len", 32'(cnt), 32'd20);
    tick(3);
    check_out("s1.pend_hold", 0, 0, 0);
    frame_pulse();
    check_out("s1.commit", 20, 25, 1);

    // Zero total -> 0, full-length DIV
    set_in(7, 0, 5, 2);
    toggle_measure(first, cnt);
    check("s2.busy_len", 32'(cnt), 32'd20);
    frame_pulse();
    check_out("s2.commit", 5, 0, 2);

    // 300/200 -> 150, saturates to 100
    set_in(300, 200, 30, 3);
    toggle_measure(first, cnt);
    frame_pulse();
    check_out("s3.sat", 30, 100, 3);

    // Frame start during DIV is ignored; 200/3 truncates to 66
    set_in(2, 3, 40, 4);
    iUpdTgl = ~iUpdTgl;
    tick(8);
    check("s4.in_div", 32'(oBusy), 32'd1);
    frame_pulse();
    check_out("s4.frame_in_div", 30, 100, 3);
    wait_idle("s4");
    check_out("s4.pend", 30, 100, 3);
    frame_pulse();
    check_out("s4.commit", 40, 66, 4);

    // Second toggle during DIV is queued
    set_in(10, 40, 50, 5);
    iUpdTgl = ~iUpdTgl;
    tick(8);
    set_in(20, 40, 60, 6);
    iUpdTgl = ~iUpdTgl;
    tick(4);
    wait_idle("s5a");
    frame_pulse();
    check_out("s5.first", 50, 25, 5);
    check("s5.recapture_busy", 32'(oBusy), 32'd1);
    wait_idle("s5b");
    check_out("s5.second_pend", 50, 25, 5);
    frame_pulse();
    check_out("s5.second", 60, 50, 6);
    check("s5.pend_cleared", 32'(oBusy), 32'd0);

    // Toggle in PEND coinciding with frame start: no commit that frame
    set_in(30, 40, 70, 7);
    toggle_measure(first, cnt);
    set_in(36, 40, 90, 9);
    iUpdTgl = ~iUpdTgl;
    tick(2);
    iFrameStart = 1'b1;
    @(negedge clk_vga);
    iFrameStart = 1'b0;
    check_out("s6.no_commit", 60, 50, 6);
    check("s6.recapture", 32'(oBusy), 32'd1);
    wait_idle("s6");
    frame_pulse();
    check_out("s6.commit", 90, 90, 9);

    // Reset mid-DIV
    set_in(20, 40, 80, 8);
    iUpdTgl = ~iUpdTgl;
    tick(10);
    check("s7.in_div", 32'(oBusy), 32'd1);
    iReset_n = 1'b0;
    iUpdTgl  = 1'b0;
    tick(1);
    check_out("s7.in_reset", 0, 0, 0);
    check("s7.busy_reset", 32'(oBusy), 32'd0);
    tick(2);
    iReset_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_vga);
      if (oBusy) nb++;
    end
    check("s7.idle_after", 32'(nb), 32'd0);
    check_out("s7.after", 0, 0, 0);
    toggle_measure(first, cnt);
    check("s7.busy_first", 32'(first), 32'd3);
    check("s7.busy_len", 32'(cnt), 32'd20);
    frame_pulse();
    check_out("s7.commit", 80, 50, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/display_status_latch.md
DISPLAY_STATUS_LATCH -- requirements
Module: display_status_latch

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on iUpdTgl (minimum 2).
REQ-002 SHALL have parameter IDX_W, default 12, the width of the note index and note total.
REQ-003 SHALL have port clk_vga, input, 1 bit: 65 MHz pixel clock; all logic is on its rising edge.
REQ-004 SHALL have port iReset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port iUpdTgl, input, 1 bit: toggle from the player clock domain, flipped once per new status bundle.
REQ-006 SHALL have port iFreqType, input, 8 bits: current note code, 0 = silence; stable whenever iUpdTgl is stable.
REQ-007 SHALL have port iNoteIdx, input, IDX_W bits: index of the current note in the song; stable whenever iUpdTgl is stable.
REQ-008 SHALL have port iNoteTotal, input, IDX_W bits: number of notes in the song; stable whenever iUpdTgl is stable.
REQ-009 SHALL have port iSongSelected, input, 4 bits: song id, 0 = free play; stable whenever iUpdTgl is stable.
REQ-010 SHALL have port iFrameStart, input, 1 bit: one-cycle pulse from VGA timing at vcnt wrap (start of vertical blanking).
REQ-011 SHALL have port oFreqType, output, 8 bits: frame-stable note code for the keyboard renderer.
REQ-012 SHALL have port oProgress, output, 8 bits: frame-stable progress, 0..100.
REQ-013 SHALL have port oSongSelected, output, 4 bits: frame-stable song id.
REQ-014 SHALL have port oBusy, output, 1 bit: high while in CAPTURE or DIV.

Function
REQ-015 SHALL pass iUpdTgl through SYNC_STAGES flops plus one edge-detect flop; any change of the synchronised value is an update request lasting one cycle.
REQ-016 SHALL implement the FSM IDLE -> CAPTURE -> DIV -> PEND -> IDLE.
REQ-017 In CAPTURE (one cycle), the block SHALL register iFreqType, iSongSelected and iNoteTotal, and register the dividend iNoteIdx*100 (IDX_W+7 bits, zero-extended).
REQ-018 In DIV, the block SHALL run a restoring divider producing one quotient bit per cycle, for exactly IDX_W+7 cycles.
REQ-019 Division rule: if iNoteTotal == 0 the result SHALL be 0 and DIV SHALL still take its full length.
REQ-020 Division rule: a quotient > 100 SHALL saturate to 100.
REQ-021 Division rule: the quotient SHALL be truncated, not rounded.
REQ-022 In PEND, the block SHALL hold the computed result until iFrameStart; on that cycle it SHALL copy the result and the captured fields to oFreqType, oProgress and oSongSelected, then go to IDLE.
REQ-023 Outputs SHALL change only on the cycle after iFrameStart is sampled in PEND; they are never updated mid-frame.
REQ-024 An update request during DIV SHALL set the pending flag, and the current division SHALL complete.
REQ-025 An update request during PEND SHALL discard the uncommitted result and go to CAPTURE.
REQ-026 After a commit with the pending flag set, the FSM SHALL go to CAPTURE instead of IDLE and clear the flag.
REQ-027 If an update request and iFrameStart occur in the same PEND cycle, the update request SHALL win: no commit, go to CAPTURE.
REQ-028 iFrameStart in IDLE, CAPTURE or DIV SHALL have no effect.
REQ-029 Latency from an iUpdTgl edge to DIV complete SHALL be SYNC_STAGES+2+IDX_W+7 cycles; the commit then waits for the next iFrameStart.

Reset
REQ-030 While iReset_n is low, the FSM SHALL be IDLE and the pending flag, synchroniser and edge flops SHALL be 0.
REQ-031 While iReset_n is low, oFreqType, oProgress, oSongSelected and oBusy SHALL all be 0.
REQ-032 Reset asserted mid-DIV SHALL abort the division with no output change other than to 0.
REQ-033 The first request after reset release SHALL be taken only from a synchroniser value change; the reset value 0 counts as the initial state.

Structure
REQ-034 The FSM state encoding, the constant PROGRESS_MAX = 100 and the DIV length SHALL live in the shared package piano_disp_pkg.
REQ-035 The divider SHALL be a sub-module named seq_divider with start/done handshake and parameterised width; the synchroniser SHALL be inline.

Verification
REQ-036 Scenario: toggle with idx=50, total=200, freq=20, song=1, then iFrameStart -> oProgress=25, oFreqType=20, oSongSelected=1 one cycle later.
REQ-037 Scenario: idx=7, total=0 -> oProgress=0 after the next frame start; oBusy high for exactly IDX_W+8 cycles.
REQ-038 Scenario: idx=300, total=200 -> oProgress=100 (saturated).
REQ-039 Scenario: iFrameStart pulsed during DIV -> outputs unchanged; they update only at the following iFrameStart.
REQ-040 Scenario: second toggle during DIV (idx 10 then 20 of 40) -> the first result is committed (25), then 50 at a later frame; second toggle in PEND together with iFrameStart -> no commit that frame.
REQ-041 Scenario: iReset_n low for 3 cycles mid-DIV -> all outputs 0, FSM IDLE; a fresh toggle completes normally.
